// File: rtl/add_pipe_rca_if.sv
// Streaming handshake bundle for add_pipe_rca: operand side (in_*) and result side (out_*).
// The sat field exists only when ADD_PIPE_RCA_SAT_EN is defined.
interface add_pipe_rca_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef ADD_PIPE_RCA_SAT_EN
  logic             sat;

  modport master (
    output in_valid, a, b, c_in, sat, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, c_in, sat, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`else
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`endif
endinterface

// File: rtl/add_pipe_rca.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES slices, carry registered between slices.
// Optional saturation on carry-out is enabled by defining ADD_PIPE_RCA_SAT_EN.
module add_pipe_rca #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic         clk,
  input logic         rst_n,
  add_pipe_rca_if.slave bus
);

  localparam int S = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("add_pipe_rca: need WIDTH>=1, 1<=STAGES<=WIDTH and WIDTH divisible by STAGES");
  end

  logic             adv;
  logic             out_vld;
  logic [STAGES-1:0] vld_src;
  logic [STAGES-1:0] cin_src;
  logic [WIDTH-1:0] a_src    [STAGES];
  logic [WIDTH-1:0] b_src    [STAGES];
  logic [WIDTH-1:0] psum_src [STAGES];
`ifdef ADD_PIPE_RCA_SAT_EN
  logic [STAGES-1:0] sat_src;
  assign sat_src[0] = bus.sat;
`endif

  // The whole pipe stalls only when a finished result is being held at the output.
  assign adv          = bus.out_ready | ~out_vld;
  assign bus.in_ready = adv;

  assign vld_src[0]  = bus.in_valid;
  assign cin_src[0]  = bus.c_in;
  assign a_src[0]    = bus.a;
  assign b_src[0]    = bus.b;
  assign psum_src[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [S:0]       chain;
    logic [WIDTH-1:0] sum_d;
    logic             vld_q;
    logic             cry_q;
    logic [WIDTH-1:0] psum_q;
`ifdef ADD_PIPE_RCA_SAT_EN
    logic             sat_q;
`endif

    always_comb begin
      chain    = '0;
      sum_d    = psum_src[k];
      chain[0] = cin_src[k];
      for (int i = 0; i < S; i++) begin
        sum_d[k*S+i] = a_src[k][k*S+i] ^ b_src[k][k*S+i] ^ chain[i];
        chain[i+1]   = (a_src[k][k*S+i] & b_src[k][k*S+i]) |
                       (chain[i] & (a_src[k][k*S+i] ^ b_src[k][k*S+i]));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        cry_q  <= 1'b0;
        psum_q <= '0;
`ifdef ADD_PIPE_RCA_SAT_EN
        sat_q  <= 1'b0;
`endif
      end else if (adv) begin
        vld_q  <= vld_src[k];
        cry_q  <= chain[S];
        psum_q <= sum_d;
`ifdef ADD_PIPE_RCA_SAT_EN
        sat_q  <= sat_src[k];
`endif
      end
    end

    if (k < STAGES - 1) begin : g_skew
      // Operands ride along so later stages see the upper slices of the same transaction.
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[k];
          b_q <= b_src[k];
        end
      end

      assign vld_src[k+1]  = vld_q;
      assign cin_src[k+1]  = cry_q;
      assign a_src[k+1]    = a_q;
      assign b_src[k+1]    = b_q;
      assign psum_src[k+1] = psum_q;
`ifdef ADD_PIPE_RCA_SAT_EN
      assign sat_src[k+1]  = sat_q;
`endif
    end else begin : g_out
      assign out_vld       = vld_q;
      assign bus.out_valid = vld_q;
      assign bus.c_out     = cry_q;
`ifdef ADD_PIPE_RCA_SAT_EN
      assign bus.sum       = (sat_q & cry_q) ? '1 : psum_q;
`else
      assign bus.sum       = psum_q;
`endif
    end
  end

endmodule
